execute_mdu: RTL and testbench
==============================

EXECUTE_MDU -- requirements
Module: execute_mdu

Interface
REQ-001 Parameter WIDTH, 32, datapath width (>=8, even).
REQ-002 Parameter AW, 5, register-address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 StallE, FlushE  in  1 each  hazard-unit hold and bubble requests.
REQ-006 RegWriteD, MemWriteD, RegDstD  in  1 each  decode control flags.
REQ-007 ALUSrcD  in  2; ALUControlD  in  3; ResultSrcD  in  2; MdOpD  in  2.
REQ-008 RsD, RtD, RdD  in  AW each; rd1D, rd2D, SignImmD, UnsignedImmD  in  WIDTH each.
REQ-009 ForwardAE, ForwardBE  in  2 each; ALUOutM, ResultW  in  WIDTH each  forwarding sources.
REQ-010 RegWriteE, MemWriteE  out  1 each; WriteRegE, RsE, RtE  out  AW each.
REQ-011 ALUOutE, WriteDataE  out  WIDTH each  stage result and store data.
REQ-012 MdBusyE  out  1  multiply/divide in progress; hazard unit stalls while high.
REQ-013 hi, lo  out  WIDTH each  architectural HI/LO registers.

Function
REQ-014 E register priority per edge: rst low > FlushE (clear all to 0) > StallE (hold) > load from D inputs.
REQ-015 Operand forward: 1x selects ALUOutM, 01 ResultW, 00 register value; WriteDataE = forwarded B.
REQ-016 SrcB: ALUSrcE 1x UnsignedImm, 01 SignImm, 00 forwarded B; WriteRegE = RegDstE ? RdE : RtE.
REQ-017 ALU combinational, zero latency: 000 AND, 001 OR, 010 ADD, 011 XOR, 110 SUB, 111 signed SLT (1/0), others 0; wrap modulo 2^WIDTH.
REQ-018 ALUOutE: ResultSrcE 00/11 ALU, 01 lo, 10 hi.
REQ-019 MdOp: 00 none, 01 signed MULT, 10 unsigned MULTU, 11 signed DIV (only with macro, REQ-029).
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN when MdOpE != 00: latch forwarded A/B (absolute values if signed), counter = WIDTH.
REQ-021 RUN: one shift-add (or restoring-subtract) step per cycle; at counter 1 write {hi,lo}, sign-corrected, go DONE.
REQ-022 MdBusyE = (IDLE and MdOpE != 00) or RUN; busy for exactly WIDTH+1 cycles; hi/lo valid cycle after busy falls.
REQ-023 DONE->IDLE on first edge with StallE low (instruction leaves E); no restart on same instruction.
REQ-024 Signed multiply: product of magnitudes negated (2*WIDTH bits) when operand signs differ.
REQ-025 FlushE in RUN/DONE: FSM to IDLE next edge, MdBusyE low, hi/lo unchanged.
REQ-026 hi/lo change only at REQ-021 completion or reset.

Reset
REQ-027 rst low: all E registers, hi, lo = 0; FSM IDLE; counter 0; MdBusyE, RegWriteE, MemWriteE = 0 next cycle.
REQ-028 rst low mid-operation aborts; no partial result written.

Configuration
REQ-029 EXECUTE_MDU_DIV_EN defined: MdOp 11 = signed DIV, WIDTH+1 busy cycles, lo = quotient (truncate toward zero), hi = remainder (dividend sign); divisor 0 -> lo all-ones, hi = dividend.
REQ-030 EXECUTE_MDU_DIV_EN undefined: MdOp 11 is no-op, MdBusyE stays low, hi/lo unchanged, no divider logic.

Structure
REQ-031 Shared package exec_pkg: ALUControl, MdOp, ResultSrc, ForwardSel encodings and FSM state enum.
REQ-032 Sub-module mdu_iter holds FSM, counter, operand/accumulator registers, hi/lo; execute_mdu holds E register, forwarding, ALU.

Verification (WIDTH=32)
REQ-033 rd1D=5, ForwardAE=10, ALUOutM=7, ALUSrc=01, SignImm=3, ADD -> ALUOutE=0x0000000A.
REQ-034 MULT A=-3, B=7 -> MdBusyE high 33 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT started after hi=lo=0x1234, FlushE in RUN cycle 10 -> MdBusyE low next cycle, hi=lo=0x1234.
REQ-037 StallE high 3 cycles, no MdOp -> all E outputs constant; rst low during RUN -> hi=lo=0, MdBusyE=0.
REQ-038 With EXECUTE_MDU_DIV_EN: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 9/0 -> lo=0xFFFFFFFF, hi=9.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage and its iterative multiply/divide unit.
// The signed divide operation exists only in builds that define EXECUTE_MDU_DIV_EN.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MD_NONE  = 2'b00,
        MD_MULT  = 2'b01,
        MD_MULTU = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LO   = 2'b01,
        RES_HI   = 2'b10,
        RES_ALU2 = 2'b11
    } res_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier (and, with EXECUTE_MDU_DIV_EN, restoring divider)
// owning the architectural HI/LO registers.
module mdu_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [1:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             MdBusyE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
`ifdef EXECUTE_MDU_DIV_EN
    logic               div_q, rneg_q, div0_q;
    logic [WIDTH+1:0]   div_diff;
`endif

    logic               md_start, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_d, mul_res;
    logic [WIDTH-1:0]   res_hi_d, res_lo_d;

    always_comb begin
`ifdef EXECUTE_MDU_DIV_EN
        md_start  = (MdOpE == MD_MULT) || (MdOpE == MD_MULTU) || (MdOpE == MD_DIV);
        signed_op = (MdOpE == MD_MULT) || (MdOpE == MD_DIV);
`else
        md_start  = (MdOpE == MD_MULT) || (MdOpE == MD_MULTU);
        signed_op = (MdOpE == MD_MULT);
`endif
        a_neg = signed_op & SrcAE[WIDTH-1];
        b_neg = signed_op & SrcBE[WIDTH-1];
        a_mag = a_neg ? (~SrcAE + 1'b1) : SrcAE;
        b_mag = b_neg ? (~SrcBE + 1'b1) : SrcBE;

        // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        step_d  = {mul_sum, prod_q[WIDTH-1:1]};
        mul_res = neg_q ? (~step_d + 1'b1) : step_d;
        res_hi_d = mul_res[2*WIDTH-1:WIDTH];
        res_lo_d = mul_res[WIDTH-1:0];
`ifdef EXECUTE_MDU_DIV_EN
        // Divide: remainder in the upper half, dividend shifting out / quotient shifting in below.
        div_diff = {1'b0, prod_q[2*WIDTH-1:WIDTH-1]} - {2'b00, mcand_q};
        if (div_q) begin
            step_d = div_diff[WIDTH+1] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            res_lo_d = div0_q ? '1 : (neg_q ? (~step_d[WIDTH-1:0] + 1'b1) : step_d[WIDTH-1:0]);
            res_hi_d = rneg_q ? (~step_d[2*WIDTH-1:WIDTH] + 1'b1) : step_d[2*WIDTH-1:WIDTH];
        end
`endif
    end

    assign MdBusyE = ((state_q == S_IDLE) && md_start) || (state_q == S_RUN);
    assign hi = hi_q;
    assign lo = lo_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef EXECUTE_MDU_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start && !FlushE) begin
                        state_q <= S_RUN;
                        cnt_q   <= CW'(WIDTH);
                        mcand_q <= b_mag;
                        prod_q  <= {{WIDTH{1'b0}}, a_mag};
                        neg_q   <= a_neg ^ b_neg;
`ifdef EXECUTE_MDU_DIV_EN
                        div_q   <= (MdOpE == MD_DIV);
                        rneg_q  <= a_neg;
                        div0_q  <= (SrcBE == '0);
`endif
                    end
                end
                S_RUN: begin
                    if (FlushE) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q <= step_d;
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            hi_q    <= res_hi_d;
                            lo_q    <= res_lo_d;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Wait for the instruction to leave E so it cannot restart itself.
                    if (FlushE || !StallE) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_mdu.sv
// Pipeline execute stage: E register, operand forwarding, ALU and HI/LO result select.
// Define EXECUTE_MDU_DIV_EN to enable the signed divide operation in mdu_iter.
module execute_mdu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             RegDstD,
    input  logic [1:0]       ALUSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [1:0]       ResultSrcD,
    input  logic [1:0]       MdOpD,
    input  logic [AW-1:0]    RsD,
    input  logic [AW-1:0]    RtD,
    input  logic [AW-1:0]    RdD,
    input  logic [WIDTH-1:0] rd1D,
    input  logic [WIDTH-1:0] rd2D,
    input  logic [WIDTH-1:0] SignImmD,
    input  logic [WIDTH-1:0] UnsignedImmD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] ResultW,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic [AW-1:0]    WriteRegE,
    output logic [AW-1:0]    RsE,
    output logic [AW-1:0]    RtE,
    output logic [WIDTH-1:0] ALUOutE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic             MdBusyE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             reg_write_q, mem_write_q, reg_dst_q;
    logic [1:0]       alu_src_q, result_src_q, md_op_q;
    logic [2:0]       alu_ctrl_q;
    logic [AW-1:0]    rs_q, rt_q, rd_q;
    logic [WIDTH-1:0] rd1_q, rd2_q, simm_q, uimm_q;
    logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_y;

    always_ff @(posedge clk) begin
        if (!rst || FlushE) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= '0;
            result_src_q <= '0;
            md_op_q      <= '0;
            alu_ctrl_q   <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            simm_q       <= '0;
            uimm_q       <= '0;
        end else if (!StallE) begin
            reg_write_q  <= RegWriteD;
            mem_write_q  <= MemWriteD;
            reg_dst_q    <= RegDstD;
            alu_src_q    <= ALUSrcD;
            result_src_q <= ResultSrcD;
            md_op_q      <= MdOpD;
            alu_ctrl_q   <= ALUControlD;
            rs_q         <= RsD;
            rt_q         <= RtD;
            rd_q         <= RdD;
            rd1_q        <= rd1D;
            rd2_q        <= rd2D;
            simm_q       <= SignImmD;
            uimm_q       <= UnsignedImmD;
        end
    end

    always_comb begin
        if (ForwardAE[1])              src_a = ALUOutM;
        else if (ForwardAE == FWD_WB)  src_a = ResultW;
        else                           src_a = rd1_q;

        if (ForwardBE[1])              fwd_b = ALUOutM;
        else if (ForwardBE == FWD_WB)  fwd_b = ResultW;
        else                           fwd_b = rd2_q;

        if (alu_src_q[1])              src_b = uimm_q;
        else if (alu_src_q[0])         src_b = simm_q;
        else                           src_b = fwd_b;

        case (alu_ctrl_q)
            ALU_AND: alu_y = src_a & src_b;
            ALU_OR:  alu_y = src_a | src_b;
            ALU_ADD: alu_y = src_a + src_b;
            ALU_XOR: alu_y = src_a ^ src_b;
            ALU_SUB: alu_y = src_a - src_b;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_y = '0;
        endcase

        case (result_src_q)
            RES_LO:  ALUOutE = lo;
            RES_HI:  ALUOutE = hi;
            default: ALUOutE = alu_y;
        endcase
    end

    assign RegWriteE  = reg_write_q;
    assign MemWriteE  = mem_write_q;
    assign WriteRegE  = reg_dst_q ? rd_q : rt_q;
    assign RsE        = rs_q;
    assign RtE        = rt_q;
    assign WriteDataE = fwd_b;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk     (clk),
        .rst     (rst),
        .StallE  (StallE),
        .FlushE  (FlushE),
        .MdOpE   (md_op_q),
        .SrcAE   (src_a),
        .SrcBE   (fwd_b),
        .MdBusyE (MdBusyE),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_execute_mdu.sv
// Directed-vector bench for execute_mdu (WIDTH=32); divide vectors apply when
// EXECUTE_MDU_DIV_EN is defined, otherwise MdOp 11 is checked as a no-op.
module tb_execute_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallE, FlushE, RegWriteD, MemWriteD, RegDstD;
    logic [1:0]  ALUSrcD, ResultSrcD, MdOpD, ForwardAE, ForwardBE;
    logic [2:0]  ALUControlD;
    logic [4:0]  RsD, RtD, RdD;
    logic [31:0] rd1D, rd2D, SignImmD, UnsignedImmD, ALUOutM, ResultW;
    logic        RegWriteE, MemWriteE, MdBusyE;
    logic [4:0]  WriteRegE, RsE, RtE;
    logic [31:0] ALUOutE, WriteDataE, hi, lo;

    int n_chk = 0;
    int n_err = 0;

    execute_mdu #(.WIDTH(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .RegDstD(RegDstD),
        .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .ResultSrcD(ResultSrcD), .MdOpD(MdOpD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .rd1D(rd1D), .rd2D(rd2D),
        .SignImmD(SignImmD), .UnsignedImmD(UnsignedImmD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUOutM(ALUOutM), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .WriteRegE(WriteRegE),
        .RsE(RsE), .RtE(RtE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
        .MdBusyE(MdBusyE), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        RegWriteD = 0; MemWriteD = 0; RegDstD = 0;
        ALUSrcD = 0; ALUControlD = 0; ResultSrcD = 0; MdOpD = 0;
        RsD = 0; RtD = 0; RdD = 0;
        rd1D = 0; rd2D = 0; SignImmD = 0; UnsignedImmD = 0;
        ForwardAE = 0; ForwardBE = 0;
    endtask

    // Issue one MDU op, hold E (as the hazard unit would) while busy, then release.
    task automatic run_md(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        clear_d();
        MdOpD = op; rd1D = a; rd2D = b;
        tick();
        MdOpD = 0;
        StallE = 1;
        n = 0;
        while (MdBusyE && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_busy"}, 64'(n), 64'(exp_busy));
        check({tag, "_busy_low"}, 64'(MdBusyE), 64'(0));
        StallE = 0;
        ResultSrcD = 2'b01;
        tick();
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_lo_via_alu"}, 64'(ALUOutE), 64'(exp_lo));
        ResultSrcD = 2'b10;
        tick();
        check({tag, "_hi_via_alu"}, 64'(ALUOutE), 64'(exp_hi));
        check({tag, "_no_restart"}, 64'(MdBusyE), 64'(0));
        ResultSrcD = 2'b00;
    endtask

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } alu_vec_t;

    alu_vec_t alu_tab[8] = '{
        '{3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000},
        '{3'b001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0},
        '{3'b011, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0},
        '{3'b110, 32'd5,        32'd7,        32'hFFFFFFFE},
        '{3'b111, 32'hFFFFFFFF, 32'd1,        32'd1},
        '{3'b111, 32'd1,        32'hFFFFFFFF, 32'd0},
        '{3'b100, 32'h12345678, 32'h0F0F0F0F, 32'd0},
        '{3'b010, 32'hFFFFFFFF, 32'd2,        32'd1}
    };

    initial begin
        rst = 0; StallE = 0; FlushE = 0; ALUOutM = 0; ResultW = 0;
        clear_d();
        RegWriteD = 1; MemWriteD = 1; rd1D = 32'h55; MdOpD = 2'b01;
        tick(); tick();
        check("rst_regwrite", 64'(RegWriteE), 64'(0));
        check("rst_memwrite", 64'(MemWriteE), 64'(0));
        check("rst_busy", 64'(MdBusyE), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_aluout", 64'(ALUOutE), 64'(0));
        rst = 1;
        clear_d();
        tick();

        // Forwarding into A with signed-immediate B
        RegWriteD = 1; RegDstD = 1; RsD = 2; RtD = 4; RdD = 9;
        rd1D = 5; SignImmD = 3; ALUSrcD = 2'b01; ALUControlD = 3'b010;
        tick();
        ForwardAE = 2'b10; ALUOutM = 7; ResultW = 100;
        #1;
        check("fwd_a_mem", 64'(ALUOutE), 64'h0000000A);
        check("writereg_rd", 64'(WriteRegE), 64'(9));
        check("regwrite_e", 64'(RegWriteE), 64'(1));
        check("rs_e", 64'(RsE), 64'(2));
        check("rt_e", 64'(RtE), 64'(4));
        ForwardAE = 2'b01; #1;
        check("fwd_a_wb", 64'(ALUOutE), 64'(103));
        ForwardAE = 2'b11; #1;
        check("fwd_a_11", 64'(ALUOutE), 64'(10));
        ForwardAE = 2'b00; #1;
        check("fwd_a_reg", 64'(ALUOutE), 64'(8));

        // ALU vectors, B from register
        foreach (alu_tab[i]) begin
            clear_d();
            ALUControlD = alu_tab[i].ctrl; rd1D = alu_tab[i].a; rd2D = alu_tab[i].b;
            tick();
            check($sformatf("alu_%0d", i), 64'(ALUOutE), 64'(alu_tab[i].y));
        end

        // Unsigned immediate, RegDst=0, store data forwarding
        clear_d();
        rd1D = 1; rd2D = 32'hCAFE; RtD = 6; RdD = 12; ALUSrcD = 2'b10; ALUControlD = 3'b010;
        UnsignedImmD = 32'h00008000; SignImmD = 32'hFFFF8000; MemWriteD = 1;
        tick();
        check("uimm_add", 64'(ALUOutE), 64'h00008001);
        check("writereg_rt", 64'(WriteRegE), 64'(6));
        check("wdata_reg", 64'(WriteDataE), 64'h0000CAFE);
        check("memwrite_e", 64'(MemWriteE), 64'(1));
        ForwardBE = 2'b10; ALUOutM = 32'h1111; #1;
        check("wdata_fwd_mem", 64'(WriteDataE), 64'h00001111);
        ForwardBE = 2'b01; ResultW = 32'h2222; #1;
        check("wdata_fwd_wb", 64'(WriteDataE), 64'h00002222);

        // Stall holds E for three cycles while D changes
        clear_d();
        RegWriteD = 1; RegDstD = 1; RdD = 17; rd1D = 1; rd2D = 2; ALUControlD = 3'b010;
        tick();
        StallE = 1;
        RegWriteD = 0; RdD = 3; rd1D = 40; rd2D = 50; ALUControlD = 3'b110;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_alu_%0d", k), 64'(ALUOutE), 64'(3));
            check($sformatf("stall_rw_%0d", k), 64'(RegWriteE), 64'(1));
            check($sformatf("stall_wreg_%0d", k), 64'(WriteRegE), 64'(17));
        end
        FlushE = 1;
        tick();
        FlushE = 0; StallE = 0;
        check("flush_rw", 64'(RegWriteE), 64'(0));
        check("flush_alu", 64'(ALUOutE), 64'(0));

        // Multiply
        run_md("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md("mult_neg_b", 2'b01, 32'd5, 32'hFFFFFFFA, 33, 32'hFFFFFFFF, 32'hFFFFFFE2);
        run_md("multu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
`ifdef EXECUTE_MDU_DIV_EN
        run_md("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_zero", 2'b11, 32'd9, 32'd0, 33, 32'd9, 32'hFFFFFFFF);
        run_md("div_pos", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
`else
        run_md("op11_noop", 2'b11, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFE, 32'h00000001);
`endif

        // hi=lo=0x1234 via 2987060*6700417 = 0x1234 * (2^32+1)
        run_md("multu_1234", 2'b10, 32'd2987060, 32'd6700417, 33, 32'h00001234, 32'h00001234);

        // Flush in RUN cycle 10 abandons the operation
        clear_d();
        MdOpD = 2'b01; rd1D = 3; rd2D = 4;
        tick();
        MdOpD = 0; StallE = 1;
        for (int k = 0; k < 10; k++) tick();
        check("flush_run_busy_pre", 64'(MdBusyE), 64'(1));
        FlushE = 1;
        tick();
        FlushE = 0;
        check("flush_run_busy", 64'(MdBusyE), 64'(0));
        check("flush_run_hi", 64'(hi), 64'h00001234);
        check("flush_run_lo", 64'(lo), 64'h00001234);
        StallE = 0;
        for (int k = 0; k < 40; k++) tick();
        check("flush_run_lo_late", 64'(lo), 64'h00001234);
        check("flush_run_busy_late", 64'(MdBusyE), 64'(0));

        // Reset mid-RUN aborts with no partial result
        clear_d();
        MdOpD = 2'b01; rd1D = 3; rd2D = 4; RegWriteD = 1;
        tick();
        MdOpD = 0; StallE = 1;
        for (int k = 0; k < 5; k++) tick();
        rst = 0;
        tick();
        check("rst_run_hi", 64'(hi), 64'(0));
        check("rst_run_lo", 64'(lo), 64'(0));
        check("rst_run_busy", 64'(MdBusyE), 64'(0));
        check("rst_run_rw", 64'(RegWriteE), 64'(0));
        rst = 1; StallE = 0;
        clear_d();
        for (int k = 0; k < 40; k++) tick();
        check("rst_run_lo_late", 64'(lo), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
